// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared constants for the integer square-root datapath
package sqrt_pkg;

  localparam int W_DEF = 8;
  localparam int OE_N  = 12;

  // Bus-source bit positions within OE
  localparam int OE_X    = 0;
  localparam int OE_R1   = 1;
  localparam int OE_R2   = 2;
  localparam int OE_R3   = 3;
  localparam int OE_R4   = 4;
  localparam int OE_R5   = 5;
  localparam int OE_ALU1 = 6;
  localparam int OE_ALU2 = 7;
  localparam int OE_K0   = 8;
  localparam int OE_K1   = 9;
  localparam int OE_K2   = 10;
  localparam int OE_K3   = 11;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

endpackage

// File: rtl/sqrt_alu.sv
// rtl/sqrt_alu.sv - combinational add/sub/shift/pass ALU, modulo 2^W
module sqrt_alu
  import sqrt_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [1:0]   Op,
  output logic [W-1:0] Y
);

  always_comb begin
    Y = A;
    case (Op)
      OP_ADD:  Y = A + B;
      OP_SUB:  Y = A - B;
      OP_SHR:  Y = A >> 1;
      default: Y = A;
    endcase
  end

endmodule

// File: rtl/sqrt_datapath.sv
// rtl/sqrt_datapath.sv - operand/iteration/result registers, shared bus, flags
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [W-1:0]    X,
  input  logic [OE_N-1:0] OE,
  input  logic [1:0]      Op1,
  input  logic [1:0]      Op2,
  input  logic            R1,
  input  logic            R2,
  input  logic            R3,
  input  logic            R4,
  input  logic            R5,
  output logic [W-1:0]    Bus,
  output logic            Le,
  output logic [W-1:0]    Result,
  output logic            Valid,
  output logic            Err
);

  logic [W-1:0] reg1, reg2, reg3, reg4, reg5;
  logic [W-1:0] alu1_y, alu2_y;
  logic [W-1:0] src [OE_N];
  logic         load_any;
  logic         multi_hot;

  sqrt_alu #(.W(W)) u_alu1 (.A(reg1), .B(reg2), .Op(Op1), .Y(alu1_y));
  sqrt_alu #(.W(W)) u_alu2 (.A(reg2), .B(reg3), .Op(Op2), .Y(alu2_y));

  always_comb begin
    src[OE_X]    = X;
    src[OE_R1]   = reg1;
    src[OE_R2]   = reg2;
    src[OE_R3]   = reg3;
    src[OE_R4]   = reg4;
    src[OE_R5]   = reg5;
    src[OE_ALU1] = alu1_y;
    src[OE_ALU2] = alu2_y;
    src[OE_K0]   = W'(0);
    src[OE_K1]   = W'(1);
    src[OE_K2]   = W'(2);
    src[OE_K3]   = W'(3);
  end

  // Wired-OR of every enabled source keeps contention deterministic
  always_comb begin
    Bus = '0;
    for (int i = 0; i < OE_N; i++) begin
      if (OE[i]) Bus = Bus | src[i];
    end
  end

  assign load_any  = R1 | R2 | R3 | R4 | R5;
  assign multi_hot = (OE & (OE - 1'b1)) != '0;
  assign Le        = reg1 <= reg4;
  assign Result    = reg5;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      reg1  <= '0;
      reg2  <= '0;
      reg3  <= '0;
      reg4  <= '0;
      reg5  <= '0;
      Valid <= 1'b0;
      Err   <= 1'b0;
    end else begin
      if (R1) reg1 <= Bus;
      if (R2) reg2 <= Bus;
      if (R3) reg3 <= Bus;
      if (R4) reg4 <= Bus;
      if (R5) reg5 <= Bus;
      Valid <= R5;
      if (load_any && multi_hot) Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sqrt_datapath.sv
// tb/tb_sqrt_datapath.sv - directed scoreboard bench for sqrt_datapath
module tb_sqrt_datapath;

  logic        Clk;
  logic        Reset;
  logic [7:0]  X;
  logic [11:0] OE;
  logic [1:0]  Op1, Op2;
  logic        R1, R2, R3, R4, R5;
  logic [7:0]  Bus;
  logic        Le;
  logic [7:0]  Result;
  logic        Valid;
  logic        Err;

  sqrt_datapath #(.W(8)) dut (
    .Clk(Clk), .Reset(Reset), .X(X), .OE(OE), .Op1(Op1), .Op2(Op2),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5),
    .Bus(Bus), .Le(Le), .Result(Result), .Valid(Valid), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [11:0] B_X  = 12'h001, B_R1 = 12'h002, B_R2 = 12'h004;
  localparam logic [11:0] B_R3 = 12'h008, B_R4 = 12'h010, B_R5 = 12'h020;
  localparam logic [11:0] B_A1 = 12'h040, B_A2 = 12'h080, B_K0 = 12'h100;
  localparam logic [11:0] B_K1 = 12'h200, B_K2 = 12'h400, B_K3 = 12'h800;
  localparam logic [4:0]  L1 = 5'b00001, L2 = 5'b00010, L3 = 5'b00100;
  localparam logic [4:0]  L4 = 5'b01000, L5 = 5'b10000, LN = 5'b00000;
  localparam logic [1:0]  ADD = 2'b00, SUB = 2'b01, SHR = 2'b10, PAS = 2'b11;

  typedef struct {
    int         id;
    logic [4:0] mask;
    logic [7:0] bus;
    logic       le;
    logic [7:0] res;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  exp_t mon;
  int   step_no = 0;
  int   tests = 0;
  int   fails = 0;
  logic rst_drive;

  task automatic eb(input logic [7:0] v); pend.mask[0] = 1'b1; pend.bus = v;   endtask
  task automatic el(input logic v);       pend.mask[1] = 1'b1; pend.le = v;    endtask
  task automatic er(input logic [7:0] v); pend.mask[2] = 1'b1; pend.res = v;   endtask
  task automatic ev(input logic v);       pend.mask[3] = 1'b1; pend.valid = v; endtask
  task automatic ee(input logic v);       pend.mask[4] = 1'b1; pend.err = v;   endtask

  // Drive one cycle of controller inputs and queue what the monitor must see
  task automatic cyc(input logic [11:0] oe, input logic [1:0] o1, input logic [1:0] o2,
                     input logic [4:0] r, input logic [7:0] x);
    @(posedge Clk);
    #1;
    Reset = rst_drive;
    OE = oe; Op1 = o1; Op2 = o2; X = x;
    {R5, R4, R3, R2, R1} = r;
    pend.id = step_no;
    step_no++;
    q.push_back(pend);
    pend.mask = '0;
  endtask

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, want);
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      mon = q.pop_front();
      if (mon.mask[0]) chk("bus",    mon.id, Bus,          mon.bus);
      if (mon.mask[1]) chk("le",     mon.id, {7'd0, Le},    {7'd0, mon.le});
      if (mon.mask[2]) chk("result", mon.id, Result,       mon.res);
      if (mon.mask[3]) chk("valid",  mon.id, {7'd0, Valid}, {7'd0, mon.valid});
      if (mon.mask[4]) chk("err",    mon.id, {7'd0, Err},   {7'd0, mon.err});
    end
  end

  int r1seq[4] = '{4, 9, 16, 25};
  int r2seq[4] = '{5, 7, 9, 11};

  initial begin
    pend = '{default: '0};
    Reset = 1'b0; rst_drive = 1'b0;
    X = '0; OE = '0; Op1 = '0; Op2 = '0;
    {R5, R4, R3, R2, R1} = '0;
    repeat (2) @(posedge Clk);
    rst_drive = 1'b1;

    // reset state and asynchronous abort mid-run
    eb(8'd5); cyc(B_X, ADD, ADD, L1, 8'd5);
    eb(8'd9); cyc(B_X, ADD, ADD, L5, 8'd9);
    eb(8'd5); er(8'd9); ev(1'b1); cyc(B_R1, ADD, ADD, L5, 8'd0);
    rst_drive = 1'b0;
    eb(8'd0); er(8'd0); ev(1'b0); ee(1'b0); el(1'b1); cyc(B_R1, ADD, ADD, LN, 8'd0);
    eb(8'd0); cyc(B_R5, ADD, ADD, LN, 8'd0);
    rst_drive = 1'b1;

    // initial load for X=16
    eb(8'd16); cyc(B_X,  ADD, ADD, L4, 8'd16);
    eb(8'd1);  cyc(B_K1, ADD, ADD, L1, 8'd0);
    eb(8'd3);  cyc(B_K3, ADD, ADD, L2, 8'd0);
    eb(8'd2);  cyc(B_K2, ADD, ADD, L3, 8'd0);
    eb(8'd16); el(1'b1); cyc(B_R4, ADD, ADD, LN, 8'd0);

    // iterate while reg1 <= reg4
    for (int i = 0; i < 4; i++) begin
      el(1'b1); eb(8'(r1seq[i])); cyc(B_A1, ADD, ADD, L1, 8'd0);
      eb(8'(r2seq[i])); cyc(B_A2, ADD, ADD, L2, 8'd0);
    end
    el(1'b0); eb(8'd5); cyc(B_A2, ADD, SHR, L2, 8'd0);
    eb(8'd5); cyc(B_R2, ADD, ADD, L1, 8'd0);
    eb(8'd1); cyc(B_K1, ADD, ADD, L2, 8'd0);
    eb(8'd4); ev(1'b0); cyc(B_A1, SUB, ADD, L5, 8'd0);
    eb(8'd0); er(8'd4); ev(1'b1); cyc(12'h000, ADD, ADD, LN, 8'd0);
    er(8'd4); ev(1'b0); cyc(12'h000, ADD, ADD, LN, 8'd0);

    // back-to-back result loads hold Valid
    eb(8'd1); cyc(B_K1, ADD, ADD, L5, 8'd0);
    eb(8'd2); ev(1'b1); er(8'd1); cyc(B_K2, ADD, ADD, L5, 8'd0);
    ev(1'b1); er(8'd2); cyc(12'h000, ADD, ADD, LN, 8'd0);
    ev(1'b0); cyc(12'h000, ADD, ADD, LN, 8'd0);

    // modulo arithmetic and remaining opcodes
    eb(8'hFF); cyc(B_X,  ADD, ADD, L1, 8'hFF);
    eb(8'h02); cyc(B_K2, ADD, ADD, L2, 8'd0);
    eb(8'h01); cyc(B_A1, ADD, ADD, L1, 8'd0);
    eb(8'h01); cyc(B_R1, ADD, ADD, LN, 8'd0);
    eb(8'h00); cyc(B_K0, ADD, ADD, L1, 8'd0);
    eb(8'h01); cyc(B_K1, ADD, ADD, L2, 8'd0);
    eb(8'hFF); cyc(B_A1, SUB, ADD, LN, 8'd0);
    eb(8'hFF); cyc(B_A2, ADD, SUB, LN, 8'd0);
    eb(8'h01); cyc(B_A2, ADD, PAS, LN, 8'd0);
    eb(8'h81); cyc(B_X,  ADD, ADD, L1, 8'h81);
    eb(8'h40); cyc(B_A1, SHR, ADD, LN, 8'd0);
    eb(8'h81); ee(1'b0); cyc(B_A1, PAS, ADD, LN, 8'd0);

    // bus contention during a load sets sticky Err
    eb(8'h0A); cyc(B_X, ADD, ADD, L1, 8'h0A);
    eb(8'h5A); ee(1'b0); cyc(B_X | B_R1, ADD, ADD, L3, 8'h50);
    eb(8'h5A); ee(1'b1); cyc(B_R3, ADD, ADD, LN, 8'd0);
    eb(8'h01); ee(1'b1); cyc(B_K1, ADD, ADD, L2, 8'd0);
    ee(1'b1); cyc(12'h000, ADD, ADD, LN, 8'd0);
    rst_drive = 1'b0;
    eb(8'h00); ee(1'b0); er(8'd0); el(1'b1); cyc(B_R3, ADD, ADD, LN, 8'd0);
    rst_drive = 1'b1;

    // multiple sources without a load, and an undriven bus
    eb(8'h0C); cyc(B_X,  ADD, ADD, L1, 8'h0C);
    eb(8'h03); cyc(B_K3, ADD, ADD, L2, 8'd0);
    eb(8'h0F); ee(1'b0); cyc(B_R1 | B_R2, ADD, ADD, LN, 8'd0);
    eb(8'h00); ee(1'b0); cyc(12'h000, ADD, ADD, L2, 8'd0);
    eb(8'h00); ee(1'b0); cyc(B_R2, ADD, ADD, LN, 8'd0);
    eb(8'h03); ee(1'b0); cyc(B_K1 | B_K2, ADD, ADD, LN, 8'd0);
    eb(8'h0C); ee(1'b0); el(1'b0); cyc(B_R1, ADD, ADD, LN, 8'd0);

    repeat (3) @(posedge Clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
